// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: opcode-class bit positions, OPCODE_WIDTH and funct3 load
// encodings shared with the decoder stage.
// Optional feature macro used by the stage: WB_MISALIGN_TRAP_EN.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 10
`endif

package writeback_stage_pkg;

    localparam int unsigned OPCODE_W = `OPCODE_WIDTH;

    // Bit position of each instruction class inside the one-hot opcode vector.
    typedef enum int unsigned {
        OPB_RTYPE  = 0,
        OPB_ITYPE  = 1,
        OPB_LOAD   = 2,
        OPB_STORE  = 3,
        OPB_BRANCH = 4,
        OPB_JAL    = 5,
        OPB_JALR   = 6,
        OPB_LUI    = 7,
        OPB_AUIPC  = 8,
        OPB_SYSTEM = 9
    } opc_bit_e;

    // funct3 encodings of the load instructions.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    // Classes that produce a register-file result.
    localparam logic [OPCODE_W-1:0] OPC_WRITE_MASK =
        (OPCODE_W'(1) << OPB_RTYPE) | (OPCODE_W'(1) << OPB_ITYPE) |
        (OPCODE_W'(1) << OPB_LOAD)  | (OPCODE_W'(1) << OPB_JAL)   |
        (OPCODE_W'(1) << OPB_JALR)  | (OPCODE_W'(1) << OPB_LUI)   |
        (OPCODE_W'(1) << OPB_AUIPC);

    localparam logic [OPCODE_W-1:0] OPC_LOAD_MASK = OPCODE_W'(1) << OPB_LOAD;

    // Jumps write the link address instead of the ALU result.
    localparam logic [OPCODE_W-1:0] OPC_LINK_MASK =
        (OPCODE_W'(1) << OPB_JAL) | (OPCODE_W'(1) << OPB_JALR);

endpackage

// File: rtl/writeback_stage_load_align.sv
// wb_load_align: combinational load-data alignment and sign/zero extension.
// The raw memory word is shifted right by the byte offset, then sized by funct3.
module wb_load_align
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned FUNCT_WIDTH = 3
) (
    input  logic [DWIDTH-1:0]      mem_data_i,
    input  logic [1:0]             addr_lo_i,
    input  logic [FUNCT_WIDTH-1:0] funct3_i,
    output logic [DWIDTH-1:0]      data_o
);

    logic [DWIDTH-1:0] shifted;

    // Shift to the addressed byte, then extend according to the load size/sign.
    always_comb begin
        shifted = mem_data_i >> {addr_lo_i, 3'b000};
        data_o  = '0;
        if (funct3_i == FUNCT_WIDTH'(F3_LB)) begin
            data_o = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
        end else if (funct3_i == FUNCT_WIDTH'(F3_LH)) begin
            data_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
        end else if (funct3_i == FUNCT_WIDTH'(F3_LW)) begin
            data_o = shifted;
        end else if (funct3_i == FUNCT_WIDTH'(F3_LBU)) begin
            data_o = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
        end else if (funct3_i == FUNCT_WIDTH'(F3_LHU)) begin
            data_o = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Registers the result of the memory
// stage, selects register-file write data, and counts retired instructions.
// Optional feature: define WB_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW
// (adds the wb_o_exception port and suppresses the write of such loads).
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 10
`endif

module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 5,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned FUNCT_WIDTH = 3
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic                      wb_i_ce,
    input  logic                      wb_i_stall,
    input  logic                      wb_i_flush,
    input  logic [`OPCODE_WIDTH-1:0]  wb_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]    wb_i_funct3,
    input  logic [AWIDTH-1:0]         wb_i_addr_rd,
    input  logic [DWIDTH-1:0]         wb_i_alu_result,
    input  logic [DWIDTH-1:0]         wb_i_mem_data,
    input  logic [1:0]                wb_i_mem_addr_lo,
    input  logic [PC_WIDTH-1:0]       wb_i_pc,
    output logic                      wb_o_we,
    output logic [AWIDTH-1:0]         wb_o_addr_rd,
    output logic [DWIDTH-1:0]         wb_o_data_rd,
    output logic                      wb_o_ce,
    output logic                      wb_o_stall,
    output logic [DWIDTH-1:0]         wb_o_instret
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic                      wb_o_exception
`endif
);

    logic [DWIDTH-1:0]   load_data;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [DWIDTH-1:0]   data_sel;
    logic                is_load;
    logic                wr_class;
    logic                misaligned;
    logic                wr_en;

    logic                we_q,      we_d;
    logic                ce_q,      ce_d;
    logic                stall_q,   stall_d;
    logic [AWIDTH-1:0]   addr_q,    addr_d;
    logic [DWIDTH-1:0]   data_q,    data_d;
    logic [DWIDTH-1:0]   instret_q, instret_d;
`ifdef WB_MISALIGN_TRAP_EN
    logic                exc_q,     exc_d;
`endif

    wb_load_align #(
        .DWIDTH      (DWIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_load_align (
        .mem_data_i (wb_i_mem_data),
        .addr_lo_i  (wb_i_mem_addr_lo),
        .funct3_i   (wb_i_funct3),
        .data_o     (load_data)
    );

    assign pc_plus4 = wb_i_pc + PC_WIDTH'(4);

    // Classify the incoming instruction and pick its write-back value.
    always_comb begin
        is_load  = |(wb_i_opcode & OPC_LOAD_MASK);
        wr_class = |(wb_i_opcode & OPC_WRITE_MASK);
        if (is_load) begin
            data_sel = load_data;
        end else if (|(wb_i_opcode & OPC_LINK_MASK)) begin
            data_sel = DWIDTH'(pc_plus4);
        end else begin
            data_sel = wb_i_alu_result;
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    // Halfword loads need an even offset, word loads a zero offset.
    always_comb begin
        misaligned = 1'b0;
        if (is_load) begin
            if ((wb_i_funct3 == FUNCT_WIDTH'(F3_LH) || wb_i_funct3 == FUNCT_WIDTH'(F3_LHU))
                && wb_i_mem_addr_lo[0]) begin
                misaligned = 1'b1;
            end
            if (wb_i_funct3 == FUNCT_WIDTH'(F3_LW) && wb_i_mem_addr_lo != 2'b00) begin
                misaligned = 1'b1;
            end
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // x0 is hard-wired, so a write to it is dropped; trapped loads never write.
    assign wr_en = wr_class && (wb_i_addr_rd != '0) && !misaligned;

    // Next-state selection: flush beats stall, stall beats a new capture.
    always_comb begin
        we_d      = we_q;
        ce_d      = ce_q;
        stall_d   = wb_i_stall;
        addr_d    = addr_q;
        data_d    = data_q;
        instret_d = instret_q;
`ifdef WB_MISALIGN_TRAP_EN
        exc_d     = exc_q;
`endif
        if (wb_i_flush) begin
            ce_d = 1'b0;
            we_d = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            exc_d = 1'b0;
`endif
        end else if (wb_i_stall) begin
            // Hold the result but drop the one-shot strobes so nothing repeats.
            we_d = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            exc_d = 1'b0;
`endif
        end else if (wb_i_ce) begin
            ce_d      = 1'b1;
            we_d      = wr_en;
            addr_d    = wb_i_addr_rd;
            data_d    = data_sel;
            instret_d = instret_q + DWIDTH'(1);
`ifdef WB_MISALIGN_TRAP_EN
            exc_d     = misaligned;
`endif
        end else begin
            ce_d = 1'b0;
            we_d = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            exc_d = 1'b0;
`endif
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            we_q      <= 1'b0;
            ce_q      <= 1'b0;
            stall_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            instret_q <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            exc_q     <= 1'b0;
`endif
        end else begin
            we_q      <= we_d;
            ce_q      <= ce_d;
            stall_q   <= stall_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            instret_q <= instret_d;
`ifdef WB_MISALIGN_TRAP_EN
            exc_q     <= exc_d;
`endif
        end
    end

    assign wb_o_we      = we_q;
    assign wb_o_ce      = ce_q;
    assign wb_o_stall   = stall_q;
    assign wb_o_addr_rd = addr_q;
    assign wb_o_data_rd = data_q;
    assign wb_o_instret = instret_q;
`ifdef WB_MISALIGN_TRAP_EN
    assign wb_o_exception = exc_q;
`endif

endmodule
